// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state encoding, ALU op codes and RV32 subset decode constants
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_NE  = 4'b0110;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_MEM = 3'b000;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_ORI = 3'b110;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    // Returns S_TRAP for anything outside the supported subset; the caller decides what illegal means.
    function automatic state_t decode_next(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic [6:0] funct7);
        state_t nxt;
        nxt = S_TRAP;
        case (opcode)
            OP_LOAD, OP_STORE: if (funct3 == F3_MEM) nxt = S_MEM_ADDR;
            OP_RTYPE: if (funct7 == 7'd0 &&
                          (funct3 == F3_ADD || funct3 == F3_AND || funct3 == F3_SLL))
                          nxt = S_EXEC_R;
            OP_ITYPE:  if (funct3 == F3_ORI) nxt = S_EXEC_I;
            OP_BRANCH: if (funct3 == F3_BNE) nxt = S_BRANCH;
            default: ;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - maps current state and funct fields to the ALU operation code
module mc_alu_decode
    import mc_pkg::*;
(
    input  state_t      state,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [3:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (state)
            S_EXEC_R: begin
                if (funct7 == 7'd0) begin
                    case (funct3)
                        F3_AND:  alu_control = ALU_AND;
                        F3_SLL:  alu_control = ALU_SLL;
                        default: alu_control = ALU_ADD;
                    endcase
                end
            end
            S_EXEC_I: alu_control = ALU_OR;
            S_BRANCH: alu_control = ALU_NE;
            default:  alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle control FSM with memory wait counter
// Optional feature: MC_ILLEGAL_TRAP_EN sends illegal instructions to a TRAP state held until reset.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_control,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_retired,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
);

    localparam int          CW       = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT  = CW'(WAIT_LIMIT);
    localparam logic        LIMIT_EN = (WAIT_LIMIT > 0);

`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT    = S_TRAP;
    localparam logic   ILLEGAL_RETIRES = 1'b0;
`else
    localparam state_t ILLEGAL_NEXT    = S_FETCH;
    localparam logic   ILLEGAL_RETIRES = 1'b1;
`endif

    state_t          state;
    state_t          next_state;
    state_t          decoded;
    logic [CW-1:0]   wait_cnt;
    logic            is_mem;
    logic            timeout;
    logic            illegal;
    logic [3:0]      dec_alu;

    assign decoded   = decode_next(opcode, funct3, funct7);
    assign illegal   = (decoded == S_TRAP);
    assign is_mem    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout   = LIMIT_EN && is_mem && !mem_ready && (wait_cnt == LIMIT);
    assign state_dbg = state;

    mc_alu_decode u_alu_decode (
        .state       (state),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_alu)
    );

    assign alu_control = reset ? ALU_ADD : dec_alu;
    assign mem_timeout = timeout && !reset;

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = timeout ? S_FETCH : (mem_ready ? S_DECODE : S_FETCH);
            S_DECODE:   next_state = illegal ? ILLEGAL_NEXT : decoded;
            S_MEM_ADDR: next_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   next_state = timeout ? S_FETCH : (mem_ready ? S_MEM_WB : S_MEM_RD);
            S_MEM_WB:   next_state = S_FETCH;
            S_MEM_WR:   next_state = (timeout || mem_ready) ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   next_state = S_ALU_WB;
            S_EXEC_I:   next_state = S_ALU_WB;
            S_ALU_WB:   next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    // Strobes follow the state directly so the datapath sees them in the same cycle; reset masks all.
    always_comb begin
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        instr_retired = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    alu_src_b = SRC_B_FOUR;
                    mem_read  = !timeout;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a     = SRC_A_OLDPC;
                    alu_src_b     = SRC_B_IMM;
                    instr_retired = illegal && ILLEGAL_RETIRES;
                end
                S_MEM_ADDR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end
                S_MEM_RD: begin
                    iord     = 1'b1;
                    mem_read = !timeout;
                end
                S_MEM_WB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEM_WR: begin
                    iord          = 1'b1;
                    mem_write     = !timeout;
                    instr_retired = mem_ready;
                end
                S_EXEC_R: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                end
                S_EXEC_I: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end
                S_ALU_WB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = SRC_A_RS1;
                    alu_src_b     = SRC_B_RS2;
                    pc_write      = !zero;
                    pc_src        = !zero;
                    instr_retired = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The counter restarts whenever a memory state is (re)entered, including FETCH retrying itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state || timeout)
                wait_cnt <= '0;
            else if (is_mem && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized scoreboard bench for multicycle_control
module tb_multicycle_control;

    localparam int LIMIT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_control;
    logic [1:0] alu_src_a, alu_src_b;
    logic       iord, mem_read, mem_write, ir_write, pc_write, pc_src;
    logic       reg_write, mem_to_reg, instr_retired, mem_timeout;
    logic [3:0] state_dbg;

    multicycle_control #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .alu_control(alu_control),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .instr_retired(instr_retired),
        .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] ADD = 4'b0010, AND_ = 4'b0000, OR_ = 4'b0001, SLL = 4'b1000, NE = 4'b0110;
    localparam logic [9:0] IORD = 10'b1000000000, RD  = 10'b0100000000, WR  = 10'b0010000000;
    localparam logic [9:0] IRW  = 10'b0001000000, PCW = 10'b0000100000, PSRC = 10'b0000010000;
    localparam logic [9:0] RW   = 10'b0000001000, M2R = 10'b0000000100, RET = 10'b0000000010;
    localparam logic [9:0] TO   = 10'b0000000001, NONE = 10'b0000000000;

    localparam int K_ADD = 0, K_AND = 1, K_SLL = 2, K_ORI = 3, K_LB = 4, K_SB = 5, K_BNE = 6, K_ILL = 7;

    typedef struct {
        logic [17:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   retired_seen = 0;
    int   retired_exp = 0;

    logic [16:0] illegal_tab [6] = '{
        {7'b1111111, 3'b000, 7'b0000000},
        {7'b0000011, 3'b010, 7'b0000000},
        {7'b0110011, 3'b000, 7'b0100000},
        {7'b0110011, 3'b100, 7'b0000000},
        {7'b0010011, 3'b000, 7'b0000000},
        {7'b1100011, 3'b000, 7'b0000000}
    };

    function automatic logic [17:0] vec(logic [3:0] op, logic [1:0] a, logic [1:0] b, logic [9:0] s);
        return {op, a, b, s};
    endfunction

    function automatic int classify(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        if (op == 7'b0000011 && f3 == 3'b000) return K_LB;
        if (op == 7'b0100011 && f3 == 3'b000) return K_SB;
        if (op == 7'b0010011 && f3 == 3'b110) return K_ORI;
        if (op == 7'b1100011 && f3 == 3'b001) return K_BNE;
        if (op == 7'b0110011 && f7 == 7'd0) begin
            if (f3 == 3'b000) return K_ADD;
            if (f3 == 3'b111) return K_AND;
            if (f3 == 3'b001) return K_SLL;
        end
        return K_ILL;
    endfunction

    // Monitor: every cycle the DUT presents a control word that is checked against the queued one.
    always @(negedge clk) begin
        logic [17:0] act;
        exp_t        e;
        act = {alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
               pc_write, pc_src, reg_write, mem_to_reg, instr_retired, mem_timeout};
        if (instr_retired) retired_seen++;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b at %0t", e.tag, act, e.v, $time);
            end
        end
    end

    task automatic step(input logic rst, input logic rdy, input logic [17:0] v, input string tag);
        exp_t e;
        reset     = rst;
        mem_ready = rdy;
        e.v   = v;
        e.tag = tag;
        q.push_back(e);
        if (v[1]) retired_exp++;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [17:0] v, input string tag);
        step(1'b0, 1'($urandom_range(0, 1)), v, tag);
    endtask

    task automatic mem_phase(input logic [17:0] busy, input logic [17:0] done, input logic [17:0] tmo,
                             input int waits, input string tag, output bit timed_out);
        timed_out = (LIMIT > 0) && (waits > LIMIT);
        for (int i = 0; i < (timed_out ? LIMIT : waits); i++)
            step(1'b0, 1'b0, busy, {tag, "_wait"});
        if (timed_out) step(1'b0, 1'b0, tmo, {tag, "_timeout"});
        else           step(1'b0, 1'b1, done, tag);
    endtask

    task automatic fetch(input int waits);
        bit t;
        do begin
            mem_phase(vec(ADD, 2'b00, 2'b01, RD), vec(ADD, 2'b00, 2'b01, RD | IRW | PCW),
                      vec(ADD, 2'b00, 2'b01, TO), waits, "fetch", t);
            waits = $urandom_range(0, 2);
        end while (t);
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input int fw, input int mw);
        int k;
        bit t;
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        zero   = z;
        fetch(fw);
        k = classify(op, f3, f7);
        if (k == K_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
            tick(vec(ADD, 2'b01, 2'b10, NONE), "decode_illegal");
            repeat (3) tick(vec(ADD, 2'b00, 2'b00, NONE), "trap_hold");
            step(1'b1, 1'b0, vec(ADD, 2'b00, 2'b00, NONE), "trap_reset");
`else
            tick(vec(ADD, 2'b01, 2'b10, RET), "decode_illegal");
`endif
            return;
        end
        tick(vec(ADD, 2'b01, 2'b10, NONE), "decode");
        case (k)
            K_LB: begin
                tick(vec(ADD, 2'b10, 2'b10, NONE), "mem_addr");
                mem_phase(vec(ADD, 2'b00, 2'b00, IORD | RD), vec(ADD, 2'b00, 2'b00, IORD | RD),
                          vec(ADD, 2'b00, 2'b00, IORD | TO), mw, "mem_rd", t);
                if (!t) tick(vec(ADD, 2'b00, 2'b00, RW | M2R | RET), "mem_wb");
            end
            K_SB: begin
                tick(vec(ADD, 2'b10, 2'b10, NONE), "mem_addr");
                mem_phase(vec(ADD, 2'b00, 2'b00, IORD | WR), vec(ADD, 2'b00, 2'b00, IORD | WR | RET),
                          vec(ADD, 2'b00, 2'b00, IORD | TO), mw, "mem_wr", t);
            end
            K_ADD, K_AND, K_SLL: begin
                tick(vec((k == K_ADD) ? ADD : (k == K_AND) ? AND_ : SLL, 2'b10, 2'b00, NONE), "exec_r");
                tick(vec(ADD, 2'b00, 2'b00, RW | RET), "alu_wb");
            end
            K_ORI: begin
                tick(vec(OR_, 2'b10, 2'b10, NONE), "exec_i");
                tick(vec(ADD, 2'b00, 2'b00, RW | RET), "alu_wb");
            end
            default: begin
                tick(vec(NE, 2'b10, 2'b00, z ? RET : (PCW | PSRC | RET)), "branch");
            end
        endcase
    endtask

    initial begin
        logic [16:0] ill;
        int          r;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, vec(ADD, 2'b00, 2'b00, NONE), "reset");
        step(1'b1, 1'b1, vec(ADD, 2'b00, 2'b00, NONE), "reset");

        issue(7'b0110011, 3'b000, 7'd0, 1'b0, 0, 0);          // add x3,x1,x2
        issue(7'b0000011, 3'b000, 7'd0, 1'b0, 0, 3);          // lb, ready arrives exactly at the limit
        issue(7'b0100011, 3'b000, 7'd0, 1'b0, 0, 0);          // sb
        issue(7'b1100011, 3'b001, 7'd0, 1'b1, 0, 0);          // bne equal operands
        issue(7'b1100011, 3'b001, 7'd0, 1'b0, 0, 0);          // bne differing operands
        issue(7'b0110011, 3'b111, 7'd0, 1'b0, LIMIT + 1, 0);  // fetch times out once
        issue(7'b0000011, 3'b000, 7'd0, 1'b0, 0, LIMIT + 2);  // load aborted by timeout
        issue(7'b1111111, 3'b000, 7'd0, 1'b0, 0, 0);          // illegal opcode

        // reset lands while a store is waiting on memory
        opcode = 7'b0100011; funct3 = 3'b000; funct7 = 7'd0;
        fetch(0);
        tick(vec(ADD, 2'b01, 2'b10, NONE), "decode");
        tick(vec(ADD, 2'b10, 2'b10, NONE), "mem_addr");
        step(1'b0, 1'b0, vec(ADD, 2'b00, 2'b00, IORD | WR), "mem_wr_wait");
        step(1'b1, 1'b0, vec(ADD, 2'b00, 2'b00, NONE), "reset_in_mem_wr");

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: issue(7'b0110011, 3'b000, 7'd0, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
                1: issue(7'b0110011, 3'b111, 7'd0, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
                2: issue(7'b0110011, 3'b001, 7'd0, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
                3: issue(7'b0010011, 3'b110, 7'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
                4: issue(7'b0000011, 3'b000, 7'($urandom), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 4), $urandom_range(0, 5));
                5: issue(7'b0100011, 3'b000, 7'($urandom), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 4), $urandom_range(0, 5));
                6: issue(7'b1100011, 3'b001, 7'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
                default: begin
                    ill = illegal_tab[$urandom_range(0, 5)];
                    issue(ill[16:10], ill[9:7], ill[6:0], 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
                end
            endcase
        end

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        checks++;
        if (retired_seen != retired_exp) begin
            errors++;
            $display("FAIL retire_count: got %0d expected %0d", retired_seen, retired_exp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
